// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller:
// FSM states, opcodes, ALU ops and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECR     = 4'd6,
    EXECI     = 4'd7,
    ALUWB     = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR      = 4'd11,
    JALR_LINK = 4'd12,
    TRAP      = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Which branch funct3 codes exist in this build.
  function automatic logic br_legal(
    input logic [2:0] f3,
    input logic       full
  );
    if (!full) return f3 == 3'b000;
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Branch outcome from the flags of rs1 - rs2; c=1 means no borrow.
  function automatic logic br_taken(
    input logic [2:0] f3,
    input logic       z,
    input logic       n,
    input logic       c,
    input logic       v
  );
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = !z;
      3'b100:  t = n ^ v;
      3'b101:  t = !(n ^ v);
      3'b110:  t = !c;
      3'b111:  t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/aludec_ext.sv
// ALU operation decoder for R/I-type instructions, with an
// illegal flag for ops the configured ALU cannot perform.
import riscv_ctrl_pkg::*;

module aludec_ext #(
  parameter int ALUCTRL_W = 3
) (
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 op5,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 alu_illegal
);

  localparam bit EXT = (ALUCTRL_W >= 4);

  logic [3:0] code;

  // Map funct3/funct7b5 onto an ALU op; extended ops need a wide ALU.
  always_comb begin
    code        = ALU_ADD;
    alu_illegal = 1'b0;
    unique case (funct3)
      3'b000: code = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010: code = ALU_SLT;
      3'b110: code = ALU_OR;
      3'b111: code = ALU_AND;
      3'b001: begin
        code        = EXT ? ALU_SLL : ALU_ADD;
        alu_illegal = !EXT;
      end
      3'b011: begin
        code        = EXT ? ALU_SLTU : ALU_ADD;
        alu_illegal = !EXT;
      end
      3'b100: begin
        code        = EXT ? ALU_XOR : ALU_ADD;
        alu_illegal = !EXT;
      end
      3'b101: begin
        if (EXT) code = funct7b5 ? ALU_SRA : ALU_SRL;
        alu_illegal = !EXT;
      end
    endcase
  end

  assign ALUControl = ALUCTRL_W'(code);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/
// writeback with memory handshake and a sticky illegal trap.
import riscv_ctrl_pkg::*;

module multicycle_controller #(
  parameter int ALUCTRL_W   = 3,
  parameter bit FULL_BRANCH = 1'b1,
  parameter bit MEM_WAIT    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Neg,
  input  logic                 Carry,
  input  logic                 Overflow,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic                 RegWrite,
  output logic                 illegal
);

  localparam logic [ALUCTRL_W-1:0] C_ADD = ALUCTRL_W'(ALU_ADD);
  localparam logic [ALUCTRL_W-1:0] C_SUB = ALUCTRL_W'(ALU_SUB);

  state_t                 state;
  state_t                 dec_next;
  logic                   ready;
  logic [ALUCTRL_W-1:0]   alu_dec;
  logic                   alu_illegal;

  assign ready = MEM_WAIT ? mem_ready : 1'b1;

  aludec_ext #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_aludec (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .ALUControl  (alu_dec),
    .alu_illegal (alu_illegal)
  );

  // Instruction class decides the execute path; bad encodings trap.
  always_comb begin
    dec_next = TRAP;
    case (op)
      OP_LOAD,
      OP_STORE:  dec_next = MEMADR;
      OP_RTYPE:  dec_next = alu_illegal ? TRAP : EXECR;
      OP_ITYPE:  dec_next = alu_illegal ? TRAP : EXECI;
      OP_BRANCH: dec_next =
                   br_legal(funct3, FULL_BRANCH) ? BRANCH : TRAP;
      OP_JAL:    dec_next = JAL;
      OP_JALR:   dec_next = JALR;
      default:   dec_next = TRAP;
    endcase
  end

  // State sequencing plus the sticky trap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
    end else begin
      unique case (state)
        FETCH:    if (ready) state <= DECODE;
        DECODE: begin
          state <= dec_next;
          if (dec_next == TRAP) illegal <= 1'b1;
        end
        MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  if (ready) state <= MEMWB;
        MEMWRITE: if (ready) state <= FETCH;
        EXECR,
        EXECI,
        JAL,
        JALR_LINK: state <= ALUWB;
        JALR:      state <= JALR_LINK;
        MEMWB,
        ALUWB,
        BRANCH:    state <= FETCH;
        TRAP:      state <= TRAP;
        default:   state <= FETCH;
      endcase
    end
  end

  // Moore decode of the datapath controls; strobes off in reset.
  always_comb begin
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_REG;
    ALUControl = C_ADD;
    ResultSrc  = RES_ALUOUT;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    unique case (state)
      FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = ready;
        PCWrite   = ready;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_B;
      end
      MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ALUControl = alu_dec;
      end
      EXECI: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        ALUControl = alu_dec;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        ALUControl = C_SUB;
        PCWrite    =
          br_taken(funct3, Zero, Neg, Carry, Overflow);
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      JALR: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
      end
      JALR_LINK: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
      end
      TRAP: begin
      end
      default: begin
      end
    endcase
    if (reset) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, hand sequences
// and random stimulus against a step-list reference model.
module tb_multicycle_controller;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] RI  = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] JR  = 7'b1100111;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] op [2];
  logic [2:0] f3 [2];
  logic f7 [2];
  logic z [2];
  logic n [2];
  logic c [2];
  logic v [2];
  logic rdy [2];
  logic mem_req [2];
  logic AdrSrc [2];
  logic MemWrite [2];
  logic IRWrite [2];
  logic PCWrite [2];
  logic [1:0] ALUSrcA [2];
  logic [1:0] ALUSrcB [2];
  logic [2:0] alu0;
  logic [3:0] alu1;
  logic [1:0] ResultSrc [2];
  logic [1:0] ImmSrc [2];
  logic RegWrite [2];
  logic illegal [2];

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  multicycle_controller #(
    .ALUCTRL_W(3), .FULL_BRANCH(1'b1), .MEM_WAIT(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .op(op[0]), .funct3(f3[0]),
    .funct7b5(f7[0]), .Zero(z[0]), .Neg(n[0]), .Carry(c[0]),
    .Overflow(v[0]), .mem_ready(rdy[0]), .mem_req(mem_req[0]),
    .AdrSrc(AdrSrc[0]), .MemWrite(MemWrite[0]),
    .IRWrite(IRWrite[0]), .PCWrite(PCWrite[0]),
    .ALUSrcA(ALUSrcA[0]), .ALUSrcB(ALUSrcB[0]),
    .ALUControl(alu0), .ResultSrc(ResultSrc[0]),
    .ImmSrc(ImmSrc[0]), .RegWrite(RegWrite[0]),
    .illegal(illegal[0])
  );

  multicycle_controller #(
    .ALUCTRL_W(4), .FULL_BRANCH(1'b0), .MEM_WAIT(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .op(op[1]), .funct3(f3[1]),
    .funct7b5(f7[1]), .Zero(z[1]), .Neg(n[1]), .Carry(c[1]),
    .Overflow(v[1]), .mem_ready(rdy[1]), .mem_req(mem_req[1]),
    .AdrSrc(AdrSrc[1]), .MemWrite(MemWrite[1]),
    .IRWrite(IRWrite[1]), .PCWrite(PCWrite[1]),
    .ALUSrcA(ALUSrcA[1]), .ALUSrcB(ALUSrcB[1]),
    .ALUControl(alu1), .ResultSrc(ResultSrc[1]),
    .ImmSrc(ImmSrc[1]), .RegWrite(RegWrite[1]),
    .illegal(illegal[1])
  );

  // configuration of each instance, mirrored for the model
  int cw    [2] = '{3, 4};
  bit cfull [2] = '{1'b1, 1'b0};
  bit cwait [2] = '{1'b1, 1'b0};

  // model: current step name plus remaining steps of instruction
  string mst  [2];
  string seq  [2][4];
  int    slen [2];
  int    spos [2];
  bit    mill [2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [18:0] obs(input int k);
    logic [3:0] a;
    a = (k == 0) ? {1'b0, alu0} : alu1;
    return {mem_req[k], AdrSrc[k], MemWrite[k], IRWrite[k],
            PCWrite[k], ALUSrcA[k], ALUSrcB[k], a, ResultSrc[k],
            ImmSrc[k], RegWrite[k], illegal[k]};
  endfunction

  function automatic bit legal_ref(input int k);
    logic [2:0] f;
    bit basic;
    f = f3[k];
    basic = (f == 0) || (f == 2) || (f == 6) || (f == 7);
    if (op[k] == LD || op[k] == ST || op[k] == JL || op[k] == JR)
      return 1'b1;
    if (op[k] == RR || op[k] == RI) return basic || cw[k] == 4;
    if (op[k] == BR)
      return cfull[k] ? (f != 2 && f != 3) : (f == 0);
    return 1'b0;
  endfunction

  function automatic logic [3:0] alu_ref(input int k);
    case (f3[k])
      3'd0: return (op[k] == RR && f7[k]) ? 4'd1 : 4'd0;
      3'd1: return 4'd7;
      3'd2: return 4'd5;
      3'd3: return 4'd6;
      3'd4: return 4'd4;
      3'd5: return f7[k] ? 4'd9 : 4'd8;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  function automatic bit taken_ref(input int k);
    bit lt;
    lt = n[k] != v[k];
    case (f3[k])
      3'd0: return z[k];
      3'd1: return !z[k];
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return !c[k];
      3'd7: return c[k];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [18:0] exp_ref(input int k);
    bit r;
    logic mq, ad, mw, ir, pw, rw;
    logic [1:0] a, b, rs, im;
    logic [3:0] al;
    string s;
    r = cwait[k] ? rdy[k] : 1'b1;
    {mq, ad, mw, ir, pw, rw} = '0;
    {a, b, rs, im} = '0;
    al = 4'd0;
    s = reset ? "FETCH" : mst[k];
    if (s == "FETCH") begin
      mq = !reset; b = 2; rs = 2; ir = r && !reset; pw = ir;
    end else if (s == "DECODE") begin
      a = 1; b = 1; im = 2;
    end else if (s == "MEMADR") begin
      a = 2; b = 1; im = (op[k] == ST) ? 2'd1 : 2'd0;
    end else if (s == "MEMREAD") begin
      mq = 1; ad = 1;
    end else if (s == "MEMWB") begin
      rs = 1; rw = 1;
    end else if (s == "MEMWRITE") begin
      mq = 1; ad = 1; mw = 1;
    end else if (s == "EXECR") begin
      a = 2; al = alu_ref(k);
    end else if (s == "EXECI") begin
      a = 2; b = 1; al = alu_ref(k);
    end else if (s == "ALUWB") begin
      rw = 1;
    end else if (s == "BRANCH") begin
      a = 2; al = 1; pw = taken_ref(k);
    end else if (s == "JAL") begin
      a = 1; b = 2; pw = 1;
    end else if (s == "JALR") begin
      a = 2; b = 1; rs = 2; pw = 1;
    end else if (s == "JALR_LINK") begin
      a = 1; b = 2;
    end
    return {mq, ad, mw, ir, pw, a, b, al, rs, im, rw,
            reset ? 1'b0 : mill[k]};
  endfunction

  task automatic plan(input int k);
    slen[k] = 0;
    if (!legal_ref(k)) begin
      mst[k] = "TRAP";
      mill[k] = 1'b1;
      return;
    end
    if (op[k] == LD) begin
      seq[k][0] = "MEMADR"; seq[k][1] = "MEMREAD";
      seq[k][2] = "MEMWB"; slen[k] = 3;
    end else if (op[k] == ST) begin
      seq[k][0] = "MEMADR"; seq[k][1] = "MEMWRITE"; slen[k] = 2;
    end else if (op[k] == RR) begin
      seq[k][0] = "EXECR"; seq[k][1] = "ALUWB"; slen[k] = 2;
    end else if (op[k] == RI) begin
      seq[k][0] = "EXECI"; seq[k][1] = "ALUWB"; slen[k] = 2;
    end else if (op[k] == BR) begin
      seq[k][0] = "BRANCH"; slen[k] = 1;
    end else if (op[k] == JL) begin
      seq[k][0] = "JAL"; seq[k][1] = "ALUWB"; slen[k] = 2;
    end else begin
      seq[k][0] = "JALR"; seq[k][1] = "JALR_LINK";
      seq[k][2] = "ALUWB"; slen[k] = 3;
    end
    mst[k] = seq[k][0];
    spos[k] = 1;
  endtask

  task automatic advance(input int k);
    if (spos[k] < slen[k]) begin
      mst[k] = seq[k][spos[k]];
      spos[k]++;
    end else begin
      mst[k] = "FETCH";
    end
  endtask

  task automatic model_step(input int k);
    bit r;
    r = cwait[k] ? rdy[k] : 1'b1;
    if (reset) begin
      mst[k] = "FETCH"; mill[k] = 1'b0;
    end else if (mst[k] == "FETCH") begin
      if (r) mst[k] = "DECODE";
    end else if (mst[k] == "DECODE") begin
      plan(k);
    end else if (mst[k] == "MEMREAD" || mst[k] == "MEMWRITE") begin
      if (r) advance(k);
    end else if (mst[k] != "TRAP") begin
      advance(k);
    end
  endtask

  typedef struct {
    string      nm;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] zncv;
    int         ncyc;
    logic [7:0] pcw;
    logic [7:0] rw;
    logic [3:0] alu;
    bit         trap;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input string nm, input logic [6:0] o,
                      input logic [2:0] f, input logic s,
                      input logic [3:0] fl, input int nc,
                      input logic [7:0] p, input logic [7:0] w,
                      input logic [3:0] a, input bit t);
    vec_t x;
    x.nm = nm; x.op = o; x.f3 = f; x.f7 = s; x.zncv = fl;
    x.ncyc = nc; x.pcw = p; x.rw = w; x.alu = a; x.trap = t;
    vq.push_back(x);
  endtask

  task automatic start();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic set_in(input int k, input logic [6:0] o,
                        input logic [2:0] f, input logic s);
    op[k] = o; f3[k] = f; f7[k] = s;
  endtask

  initial begin
    vec_t x;
    bit rs [10];
    logic [3:0] e4;
    int tcnt;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      set_in(k, RR, 3'd0, 1'b0);
      {z[k], n[k], c[k], v[k]} = 4'b0;
      rdy[k] = 1'b1;
      mst[k] = "FETCH"; mill[k] = 1'b0; slen[k] = 0; spos[k] = 0;
    end
    #2;
    chk("reset0", obs(0), 19'b00000_00_10_0000_10_00_0_0);
    chk("reset1", obs(1), 19'b00000_00_10_0000_10_00_0_0);

    addv("add",  RR, 3'd0, 1'b0, 4'h0, 4, 8'h01, 8'h08, 4'd0, 0);
    addv("sub",  RR, 3'd0, 1'b1, 4'h0, 4, 8'h01, 8'h08, 4'd1, 0);
    addv("addi", RI, 3'd0, 1'b1, 4'h0, 4, 8'h01, 8'h08, 4'd0, 0);
    addv("and",  RR, 3'd7, 1'b0, 4'h0, 4, 8'h01, 8'h08, 4'd2, 0);
    addv("ori",  RI, 3'd6, 1'b0, 4'h0, 4, 8'h01, 8'h08, 4'd3, 0);
    addv("slt",  RR, 3'd2, 1'b0, 4'h0, 4, 8'h01, 8'h08, 4'd5, 0);
    addv("lw",   LD, 3'd2, 1'b0, 4'h0, 5, 8'h01, 8'h10, 4'd0, 0);
    addv("sw",   ST, 3'd2, 1'b0, 4'h0, 4, 8'h01, 8'h00, 4'd0, 0);
    addv("beqT", BR, 3'd0, 1'b0, 4'h8, 3, 8'h05, 8'h00, 4'd1, 0);
    addv("beqN", BR, 3'd0, 1'b0, 4'h0, 3, 8'h01, 8'h00, 4'd1, 0);
    addv("bneT", BR, 3'd1, 1'b0, 4'h0, 3, 8'h05, 8'h00, 4'd1, 0);
    addv("bgeT", BR, 3'd5, 1'b0, 4'h5, 3, 8'h05, 8'h00, 4'd1, 0);
    addv("bgeN", BR, 3'd5, 1'b0, 4'h4, 3, 8'h01, 8'h00, 4'd1, 0);
    addv("bltT", BR, 3'd4, 1'b0, 4'h4, 3, 8'h05, 8'h00, 4'd1, 0);
    addv("bltuT",BR, 3'd6, 1'b0, 4'h0, 3, 8'h05, 8'h00, 4'd1, 0);
    addv("bgeuN",BR, 3'd7, 1'b0, 4'h0, 3, 8'h01, 8'h00, 4'd1, 0);
    addv("jal",  JL, 3'd0, 1'b0, 4'h0, 4, 8'h05, 8'h08, 4'd0, 0);
    addv("jalr", JR, 3'd0, 1'b0, 4'h0, 5, 8'h05, 8'h10, 4'd0, 0);
    addv("xor3", RR, 3'd4, 1'b0, 4'h0, 2, 8'h01, 8'h00, 4'd0, 1);
    addv("br010",BR, 3'd2, 1'b0, 4'h0, 2, 8'h01, 8'h00, 4'd0, 1);
    addv("op0",  7'd0, 3'd0, 1'b0, 4'h0, 2, 8'h01, 8'h00, 4'd0, 1);

    foreach (vq[i]) begin
      x = vq[i];
      set_in(0, x.op, x.f3, x.f7);
      {z[0], n[0], c[0], v[0]} = x.zncv;
      rdy[0] = 1'b1;
      start();
      for (int cy = 1; cy <= x.ncyc; cy++) begin
        @(negedge clk);
        chk({x.nm, " pcw"}, PCWrite[0], x.pcw[cy-1]);
        chk({x.nm, " rw"}, RegWrite[0], x.rw[cy-1]);
        if (cy == 3 && !x.trap)
          chk({x.nm, " alu"}, {1'b0, alu0}, x.alu);
        @(posedge clk); #1;
      end
      if (x.trap) begin
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          chk({x.nm, " trap"},
              {illegal[0], mem_req[0], IRWrite[0]}, 3'b100);
          @(posedge clk); #1;
        end
      end else begin
        @(negedge clk);
        chk({x.nm, " refetch"},
            {mem_req[0], IRWrite[0], AdrSrc[0]}, 3'b110);
        @(posedge clk); #1;
      end
    end

    // trap cleared by reset, mid-cycle
    #2 reset = 1'b1;
    #1 chk("trapclr", {illegal[0], ALUSrcB[0], ResultSrc[0]},
           5'b0_10_10);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("trapclr fetch", {mem_req[0], IRWrite[0]}, 2'b11);
    @(posedge clk); #1;

    // lw with memory wait states in FETCH and MEMREAD
    rs = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 1};
    set_in(0, LD, 3'd2, 1'b0);
    start();
    for (int cy = 1; cy <= 10; cy++) begin
      rdy[0] = rs[cy-1];
      @(negedge clk);
      e4 = {cy == 4, cy == 4, cy == 10, cy >= 7 && cy <= 9};
      chk("lwwait", {IRWrite[0], PCWrite[0], RegWrite[0],
                     AdrSrc[0]}, e4);
      @(posedge clk); #1;
    end
    rdy[0] = 1'b0;
    @(negedge clk);
    chk("lwwait end", {mem_req[0], AdrSrc[0], IRWrite[0]}, 3'b100);
    @(posedge clk); #1;

    // reset while a store waits for memory
    set_in(0, ST, 3'd2, 1'b0);
    rdy[0] = 1'b1;
    start();
    for (int cy = 1; cy <= 3; cy++) begin
      @(posedge clk); #1;
    end
    rdy[0] = 1'b0;
    for (int cy = 0; cy < 2; cy++) begin
      @(negedge clk);
      chk("swwait", {mem_req[0], AdrSrc[0], MemWrite[0]}, 3'b111);
      @(posedge clk); #1;
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("swreset", {mem_req[0], MemWrite[0]}, 2'b00);
    @(posedge clk); #1 reset = 1'b0;
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("swreset fetch", {mem_req[0], IRWrite[0], AdrSrc[0]},
        3'b110);
    @(posedge clk); #1;

    // wide ALU, beq-only branches, no memory wait (dut1)
    rdy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_in(1, RR, 3'd4, 1'b0);
        1: set_in(1, RI, 3'd5, 1'b1);
        default: set_in(1, RR, 3'd3, 1'b0);
      endcase
      start();
      @(negedge clk);
      chk("w4 nowait", IRWrite[1], 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("w4 alu", alu1, (i == 0) ? 4'd4 : (i == 1) ? 4'd9 : 4'd6);
      @(posedge clk); #1;
    end
    set_in(1, BR, 3'd1, 1'b0);
    start();
    for (int cy = 0; cy < 3; cy++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bne fb0 trap", {illegal[1], PCWrite[1]}, 2'b10);
    @(posedge clk); #1;

    // random stimulus against the model, both configurations
    start();
    for (int k = 0; k < 2; k++) begin
      mst[k] = "FETCH"; mill[k] = 1'b0;
    end
    tcnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 99) == 0) || (tcnt > 8);
      for (int k = 0; k < 2; k++) begin
        if (mst[k] == "FETCH") begin
          int p;
          p = $urandom_range(0, 15);
          op[k] = p < 2 ? LD : p < 4 ? ST : p < 7 ? RR :
                  p < 10 ? RI : p < 12 ? BR : p < 13 ? JL :
                  p < 14 ? JR : 7'($urandom_range(0, 127));
          f3[k] = 3'($urandom_range(0, 7));
          f7[k] = 1'($urandom_range(0, 1));
        end
        rdy[k] = $urandom_range(0, 3) != 0;
        {z[k], n[k], c[k], v[k]} = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      chk("rand0", obs(0), exp_ref(0));
      chk("rand1", obs(1), exp_ref(1));
      @(posedge clk);
      model_step(0);
      model_step(1);
      if (reset) tcnt = 0;
      else if (mst[0] == "TRAP" || mst[1] == "TRAP") tcnt++;
      else tcnt = 0;
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
